// File: rtl/mac_pkg.sv
// Shared types and default widths for the mac_accum multiply-accumulate path.
// Optional build macro used by this slice: MAC_ACCUM_SATURATE_EN.
package mac_pkg;

    localparam int DEF_PROD_W = 8;
    localparam int DEF_ACC_W  = 12;
    localparam int DEF_COUNT  = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_accum_if.sv
// Product-in / frame-sum-out valid/ready bundle for mac_accum.
// master drives products and takes results; slave is the accumulator.
interface mac_accum_if
    import mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W
);

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    modport master (
        output in_valid,
        output in_prod,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_prod,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_ovf
    );

endinterface

// File: rtl/accum_add.sv
// Combinational ACC_W adder: acc plus zero-extended product, with carry out.
// With MAC_ACCUM_SATURATE_EN the sum clamps to all-ones on carry.
module accum_add
    import mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] full;

    // One extra bit exposes the carry; saturation reuses it as the clamp select.
    always_comb begin
        full  = {1'b0, acc} + (ACC_W + 1)'(prod);
        carry = full[ACC_W];
`ifdef MAC_ACCUM_SATURATE_EN
        sum   = carry ? '1 : full[ACC_W-1:0];
`else
        sum   = full[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/mac_accum.sv
// Sums COUNT accepted products into one frame sum with a sticky overflow flag.
// Build option MAC_ACCUM_SATURATE_EN selects clamping instead of wrap-around.
module mac_accum
    import mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int COUNT  = DEF_COUNT
) (
    input logic        clk,
    input logic        rst,
    mac_accum_if.slave bus
);

    localparam int              CNT_W = clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    state_t             state;
    state_t             state_nx;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
    logic               ovf_q;
    logic               carry;
    logic               ready;
    logic               valid;
    logic               accept;
    logic               take;

    accum_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc   (acc),
        .prod  (bus.in_prod),
        .sum   (sum),
        .carry (carry)
    );

    assign accept        = bus.in_valid && ready;
    assign take          = bus.out_ready && valid;
    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.out_sum   = sum_q;
    assign bus.out_ovf   = ovf_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and handshake outputs; result is offered only while holding.
    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        valid    = 1'b0;
        unique case (state)
            ACCUM: begin
                ready = 1'b1;
                if (bus.in_valid && cnt == LAST) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                valid = 1'b1;
                if (bus.out_ready) begin
                    state_nx = ACCUM;
                end
            end
            default: state_nx = ACCUM;
        endcase
    end

    // Accumulate partial sums; the last product of a frame goes straight to the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else if (take) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            if (cnt == LAST) begin
                sum_q <= sum;
                ovf_q <= ovf | carry;
            end else begin
                acc <= sum;
                cnt <= cnt + CNT_W'(1);
                ovf <= ovf | carry;
            end
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// Randomised bench for mac_accum: three builds (default, ACC_W=8, COUNT=1)
// share one stimulus stream; a frame-level model predicts every output each cycle.
module tb_mac_accum;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_prod;
    logic       out_ready;

    int vectors;
    int miscompares;

    mac_accum_if #(.PROD_W(8), .ACC_W(12)) if0 ();
    mac_accum_if #(.PROD_W(8), .ACC_W(8))  if1 ();
    mac_accum_if #(.PROD_W(8), .ACC_W(12)) if2 ();

    mac_accum #(.PROD_W(8), .ACC_W(12), .COUNT(4)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    mac_accum #(.PROD_W(8), .ACC_W(8), .COUNT(4)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    mac_accum #(.PROD_W(8), .ACC_W(12), .COUNT(1)) u2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    assign if0.in_valid  = in_valid;
    assign if0.in_prod   = in_prod;
    assign if0.out_ready = out_ready;
    assign if1.in_valid  = in_valid;
    assign if1.in_prod   = in_prod;
    assign if1.out_ready = out_ready;
    assign if2.in_valid  = in_valid;
    assign if2.in_prod   = in_prod;
    assign if2.out_ready = out_ready;

    logic        rdy [3];
    logic        vld [3];
    logic [11:0] sm  [3];
    logic        ov  [3];

    assign rdy[0] = if0.in_ready;
    assign rdy[1] = if1.in_ready;
    assign rdy[2] = if2.in_ready;
    assign vld[0] = if0.out_valid;
    assign vld[1] = if1.out_valid;
    assign vld[2] = if2.out_valid;
    assign sm[0]  = if0.out_sum;
    assign sm[1]  = {4'b0, if1.out_sum};
    assign sm[2]  = if2.out_sum;
    assign ov[0]  = if0.out_ovf;
    assign ov[1]  = if1.out_ovf;
    assign ov[2]  = if2.out_ovf;

    int cnt_p [3] = '{4, 4, 1};
    int wid   [3] = '{12, 8, 12};

    bit m_valid [3];
    int m_sum   [3];
    bit m_ovf   [3];
    int f_sum   [3];
    int f_n     [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_result(input int total, input int w);
        int top;
        top = (1 << w) - 1;
`ifdef MAC_ACCUM_SATURATE_EN
        return (total > top) ? top : total;
`else
        return total % (1 << w);
`endif
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 1'b0;
            m_sum[d]   = 0;
            m_ovf[d]   = 1'b0;
            f_sum[d]   = 0;
            f_n[d]     = 0;
        end
    endtask

    task automatic step(input bit r, input bit v, input int p, input bit ordy);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("u%0d.out_valid", d), 32'(vld[d]), 32'(m_valid[d]));
            chk($sformatf("u%0d.in_ready", d), 32'(rdy[d]), 32'(!m_valid[d]));
            chk($sformatf("u%0d.out_sum", d), 32'(sm[d]), 32'(m_sum[d]));
            chk($sformatf("u%0d.out_ovf", d), 32'(ov[d]), 32'(m_ovf[d]));
        end
        rst       = r;
        in_valid  = v;
        in_prod   = 8'(p);
        out_ready = ordy;
        if (r) begin
            model_reset();
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (m_valid[d]) begin
                    if (ordy) begin
                        m_valid[d] = 1'b0;
                    end
                end else if (v) begin
                    f_sum[d] += (p & 255);
                    f_n[d]++;
                    if (f_n[d] == cnt_p[d]) begin
                        m_valid[d] = 1'b1;
                        m_sum[d]   = frame_result(f_sum[d], wid[d]);
                        m_ovf[d]   = (f_sum[d] >= (1 << wid[d]));
                        f_sum[d]   = 0;
                        f_n[d]     = 0;
                    end
                end
            end
        end
    endtask

    task automatic feed(input int p, input bit ordy);
        step(1'b0, 1'b1, p, ordy);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, $urandom_range(0, 255), ordy);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_prod     = 8'd0;
        out_ready   = 1'b0;
        model_reset();

        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);

        for (int i = 0; i < 4; i++) feed(225, 1'b1);
        idle(3, 1'b1);

        feed(1, 1'b0);
        feed(2, 1'b0);
        feed(3, 1'b0);
        feed(4, 1'b0);
        idle(5, 1'b0);
        idle(1, 1'b1);
        for (int i = 0; i < 4; i++) feed(5, 1'b1);
        idle(2, 1'b1);

        feed(10, 1'b1);
        idle(1, 1'b1);
        feed(20, 1'b1);
        idle(2, 1'b1);
        feed(30, 1'b1);
        feed(40, 1'b1);
        idle(2, 1'b1);

        feed(50, 1'b1);
        feed(60, 1'b1);
        step(1'b1, 1'b1, 99, 1'b1);
        for (int i = 0; i < 4; i++) feed(1, 1'b1);
        idle(2, 1'b1);

        feed(200, 1'b1);
        feed(100, 1'b1);
        feed(0, 1'b1);
        feed(0, 1'b1);
        idle(1, 1'b1);
        for (int i = 0; i < 4; i++) feed(1, 1'b1);
        idle(2, 1'b1);

        feed(7, 1'b1);
        feed(9, 1'b1);
        idle(3, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            int p;
            p = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                            : $urandom_range(128, 255);
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0,
                 p,
                 $urandom_range(0, 2) != 0);
        end
        idle(2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
